// File: rtl/ddr3_rw_sched.sv
// Read/write command scheduler: one DDR3 command port shared by two sources.
// Optional DDR3_SCHED_STATS_EN adds turnaround and stall counters.
module ddr3_rw_sched #(
  parameter int ADDRS       = 32,
  parameter int REQID       = 4,
  parameter int MAX_SAME    = 4,
  parameter int TURN_CYCLES = 2,
  parameter int HOLD_WAIT   = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_store_i,
  output logic             wr_accept_o,
  input  logic             wr_wseq_i,
  input  logic [REQID-1:0] wr_wrid_i,
  input  logic [ADDRS-1:0] wr_addr_i,
  input  logic             rd_fetch_i,
  output logic             rd_accept_o,
  input  logic             rd_rseq_i,
  input  logic [REQID-1:0] rd_rdid_i,
  input  logic [ADDRS-1:0] rd_addr_i,
  output logic             ctl_valid_o,
  input  logic             ctl_accept_i,
  output logic             ctl_rdwr_o,
  output logic             ctl_seq_o,
  output logic [REQID-1:0] ctl_id_o,
  output logic [ADDRS-1:0] ctl_addr_o
`ifdef DDR3_SCHED_STATS_EN
  ,
  output logic [15:0]      stat_turns_o,
  output logic [15:0]      stat_stall_o
`endif
);

  localparam int CW = $clog2(MAX_SAME + 2);
  localparam int TW = $clog2(TURN_CYCLES + 2);
  localparam int HW = $clog2(HOLD_WAIT + 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TURN,
    ST_WRIT,
    ST_READ
  } state_t;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [TW-1:0]    turn_q, turn_d;
  logic             vld_q, vld_d;
  logic             rdwr_q, rdwr_d;
  logic             seq_q, seq_d;
  logic [REQID-1:0] id_q, id_d;
  logic [ADDRS-1:0] addr_q, addr_d;

  logic is_rd;
  logic own_v;
  logic own_s;
  logic oth_v;
  logic load_ok;
  logic take;
  logic pick;

  assign is_rd   = (state_q == ST_READ);
  assign own_v   = is_rd ? rd_fetch_i : wr_store_i;
  assign own_s   = is_rd ? rd_rseq_i : wr_wseq_i;
  assign oth_v   = is_rd ? wr_store_i : rd_fetch_i;
  assign load_ok = ~vld_q | ctl_accept_i;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    vld_d   = vld_q;
    rdwr_d  = rdwr_q;
    seq_d   = seq_q;
    id_d    = id_q;
    addr_d  = addr_q;
    take    = 1'b0;
    pick    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_store_i | rd_fetch_i) begin
          pick   = (wr_store_i & rd_fetch_i) ? ~last_q : rd_fetch_i;
          sel_d  = pick;
          cnt_d  = '0;
          hold_d = '0;
          if ((pick != last_q) && (TURN_CYCLES > 0)) begin
            state_d = ST_TURN;
            turn_d  = TW'(TURN_CYCLES - 1);
          end else begin
            state_d = pick ? ST_READ : ST_WRIT;
            last_d  = pick;
          end
        end
      end
      ST_TURN: begin
        // the old direction's command must leave the register first
        if (turn_q != '0) begin
          turn_d = turn_q - TW'(1);
        end else if (!vld_q) begin
          state_d = sel_q ? ST_READ : ST_WRIT;
          last_d  = sel_q;
        end
      end
      ST_WRIT, ST_READ: begin
        if (!own_v) begin
          if (hold_q >= HW'(HOLD_WAIT - 1)) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end else begin
          hold_d = '0;
          if (!own_s && oth_v && (cnt_q >= CW'(MAX_SAME))) begin
            state_d = ST_IDLE;
          end else if (load_ok) begin
            take = 1'b1;
            if (!own_s && (cnt_q < CW'(MAX_SAME))) begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (take) begin
      vld_d  = 1'b1;
      rdwr_d = is_rd;
      seq_d  = own_s;
      id_d   = is_rd ? rd_rdid_i : wr_wrid_i;
      addr_d = is_rd ? rd_addr_i : wr_addr_i;
    end else if (ctl_accept_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
      vld_q   <= 1'b0;
      rdwr_q  <= 1'b0;
      seq_q   <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      vld_q   <= vld_d;
      rdwr_q  <= rdwr_d;
      seq_q   <= seq_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
    end
  end

  assign wr_accept_o = take & ~is_rd & ~reset;
  assign rd_accept_o = take & is_rd & ~reset;
  assign ctl_valid_o = vld_q;
  assign ctl_rdwr_o  = rdwr_q;
  assign ctl_seq_o   = seq_q;
  assign ctl_id_o    = id_q;
  assign ctl_addr_o  = addr_q;

`ifdef DDR3_SCHED_STATS_EN
  logic [15:0] turns_q, turns_d;
  logic [15:0] stall_q, stall_d;

  always_comb begin
    turns_d = turns_q;
    stall_d = stall_q;
    if ((state_d == ST_TURN) && (state_q != ST_TURN) && (turns_q != 16'hFFFF)) begin
      turns_d = turns_q + 16'd1;
    end
    if (vld_q && !ctl_accept_i && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      turns_q <= '0;
      stall_q <= '0;
    end else begin
      turns_q <= turns_d;
      stall_q <= stall_d;
    end
  end

  assign stat_turns_o = turns_q;
  assign stat_stall_o = stall_q;
`endif

endmodule

// File: tb/tb_ddr3_rw_sched.sv
// Testbench for ddr3_rw_sched: source FIFO models, command scoreboard,
// directed scheduling scenarios and a randomized soak.
module tb_ddr3_rw_sched;

  localparam int ADDRS       = 32;
  localparam int REQID       = 4;
  localparam int MAX_SAME    = 4;
  localparam int TURN_CYCLES = 2;
  localparam int HOLD_WAIT   = 3;

  typedef struct packed {
    logic             rd;
    logic             seq;
    logic [REQID-1:0] id;
    logic [ADDRS-1:0] addr;
  } cmd_t;

  typedef struct {
    int cyc;
    bit rd;
    bit seq;
  } ev_t;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             wr_store_i = 1'b0;
  logic             wr_accept_o;
  logic             wr_wseq_i = 1'b0;
  logic [REQID-1:0] wr_wrid_i = '0;
  logic [ADDRS-1:0] wr_addr_i = '0;
  logic             rd_fetch_i = 1'b0;
  logic             rd_accept_o;
  logic             rd_rseq_i = 1'b0;
  logic [REQID-1:0] rd_rdid_i = '0;
  logic [ADDRS-1:0] rd_addr_i = '0;
  logic             ctl_valid_o;
  logic             ctl_accept_i = 1'b1;
  logic             ctl_rdwr_o;
  logic             ctl_seq_o;
  logic [REQID-1:0] ctl_id_o;
  logic [ADDRS-1:0] ctl_addr_o;
`ifdef DDR3_SCHED_STATS_EN
  logic [15:0]      stat_turns_o;
  logic [15:0]      stat_stall_o;
`endif

  ddr3_rw_sched #(
    .ADDRS(ADDRS), .REQID(REQID), .MAX_SAME(MAX_SAME),
    .TURN_CYCLES(TURN_CYCLES), .HOLD_WAIT(HOLD_WAIT)
  ) dut (
    .clock(clock), .reset(reset),
    .wr_store_i(wr_store_i), .wr_accept_o(wr_accept_o),
    .wr_wseq_i(wr_wseq_i), .wr_wrid_i(wr_wrid_i), .wr_addr_i(wr_addr_i),
    .rd_fetch_i(rd_fetch_i), .rd_accept_o(rd_accept_o),
    .rd_rseq_i(rd_rseq_i), .rd_rdid_i(rd_rdid_i), .rd_addr_i(rd_addr_i),
    .ctl_valid_o(ctl_valid_o), .ctl_accept_i(ctl_accept_i),
    .ctl_rdwr_o(ctl_rdwr_o), .ctl_seq_o(ctl_seq_o),
    .ctl_id_o(ctl_id_o), .ctl_addr_o(ctl_addr_o)
`ifdef DDR3_SCHED_STATS_EN
    , .stat_turns_o(stat_turns_o), .stat_stall_o(stat_stall_o)
`endif
  );

  always #5 clock = ~clock;

  cmd_t wq[$];
  cmd_t rq[$];
  cmd_t sb[$];
  ev_t  log_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cycle_n = 0;
  bit   rst_v = 1'b1;
  bit   wg = 1'b0;
  bit   rg = 1'b0;
  bit   cacc = 1'b1;
  bit   rand_mode = 1'b0;

  function automatic cmd_t mk(bit rd, bit seq);
    cmd_t c;
    c.rd   = rd;
    c.seq  = seq;
    c.id   = REQID'($urandom);
    c.addr = ADDRS'($urandom);
    return c;
  endfunction

  task automatic push_chain(bit rd, int len);
    for (int i = 0; i < len; i++) begin
      if (rd) rq.push_back(mk(1'b1, i != 0));
      else    wq.push_back(mk(1'b0, i != 0));
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  function automatic int find_ev(int from, output ev_t e);
    foreach (log_q[i]) begin
      if (log_q[i].cyc >= from) begin
        e = log_q[i];
        return 1;
      end
    end
    e = '{cyc: 0, rd: 1'b0, seq: 1'b0};
    return 0;
  endfunction

  function automatic int count_ev(int lo, int hi);
    int n = 0;
    foreach (log_q[i]) begin
      if (log_q[i].cyc >= lo && log_q[i].cyc <= hi) n++;
    end
    return n;
  endfunction

  // one clock: inputs change 1 time unit after the rising edge
  task automatic cyc();
    @(posedge clock);
    #1;
    cycle_n++;
    if (rand_mode) begin
      wg   = $urandom_range(0, 3) != 0;
      rg   = $urandom_range(0, 3) != 0;
      cacc = $urandom_range(0, 4) != 0;
    end
    reset        = rst_v;
    ctl_accept_i = cacc;
    wr_store_i   = wg && (wq.size() > 0);
    rd_fetch_i   = rg && (rq.size() > 0);
    if (wq.size() > 0) begin
      wr_wseq_i = wq[0].seq;
      wr_wrid_i = wq[0].id;
      wr_addr_i = wq[0].addr;
    end
    if (rq.size() > 0) begin
      rd_rseq_i = rq[0].seq;
      rd_rdid_i = rq[0].id;
      rd_addr_i = rq[0].addr;
    end
  endtask

  // monitor: compares the command register against the scoreboard
  always @(negedge clock) begin
    cmd_t got;
    if (reset) begin
      tests++;
      if (wr_accept_o || rd_accept_o) begin
        fails++;
        $display("FAIL reset_acc: got wr=%0b rd=%0b, required 0 0", wr_accept_o, rd_accept_o);
      end
      sb.delete();
    end else begin
      tests++;
      if (ctl_valid_o) begin
        got = {ctl_rdwr_o, ctl_seq_o, ctl_id_o, ctl_addr_o};
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_phantom: got valid command addr=%0h, required none", ctl_addr_o);
        end else begin
          if (got !== sb[0]) begin
            fails++;
            $display("FAIL sb_cmd: got rd=%0b seq=%0b id=%0h addr=%0h, required rd=%0b seq=%0b id=%0h addr=%0h",
                     got.rd, got.seq, got.id, got.addr, sb[0].rd, sb[0].seq, sb[0].id, sb[0].addr);
          end
          if (ctl_accept_i) void'(sb.pop_front());
        end
      end else if (sb.size() != 0) begin
        fails++;
        $display("FAIL sb_lost: got valid=0, required valid=1 with %0d pending", sb.size());
      end
      if (wr_accept_o || rd_accept_o) begin
        tests++;
        if ((wr_accept_o && rd_accept_o) || (ctl_valid_o && !ctl_accept_i) ||
            (wr_accept_o && !wr_store_i) || (rd_accept_o && !rd_fetch_i)) begin
          fails++;
          $display("FAIL acc_rule: got wr=%0b rd=%0b vld=%0b cacc=%0b, required legal accept",
                   wr_accept_o, rd_accept_o, ctl_valid_o, ctl_accept_i);
        end
        if (wr_accept_o && wq.size() > 0) begin
          sb.push_back(wq[0]);
          log_q.push_back('{cyc: cycle_n, rd: 1'b0, seq: wq[0].seq});
          void'(wq.pop_front());
        end else if (rd_accept_o && rq.size() > 0) begin
          sb.push_back(rq[0]);
          log_q.push_back('{cyc: cycle_n, rd: 1'b1, seq: rq[0].seq});
          void'(rq.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   s, k, n;
    ev_t  e, e2;
    int   runs[$];
    bit   dirs[$];

    repeat (3) cyc();
    rst_v = 1'b0;
    cyc();
    @(negedge clock);
    chk("rst_valid", ctl_valid_o, 0);
    chk("rst_rdwr", ctl_rdwr_o, 0);
    chk("rst_seq", ctl_seq_o, 0);
    chk("rst_id", ctl_id_o, 0);
    chk("rst_addr", ctl_addr_o, 0);
    chk("rst_wacc", wr_accept_o, 0);
    chk("rst_racc", rd_accept_o, 0);

    // writes only: three 4-command chains
    for (int i = 0; i < 3; i++) push_chain(1'b0, 4);
    wg = 1'b1;
    rg = 1'b0;
    cyc();
    s = cycle_n;
    repeat (20) cyc();
    chk("wonly_count", count_ev(s, s + 13), 12);
    n = find_ev(s, e);
    chk("wonly_first", e.cyc, s + 1);
    chk("wonly_dir", e.rd, 0);
    chk("wonly_b2b", count_ev(s + 1, s + 12), 12);

    // direction change from idle: one idle cycle plus the turnaround
    push_chain(1'b1, 1);
    push_chain(1'b1, 1);
    rg = 1'b1;
    cyc();
    s = cycle_n;
    repeat (15) cyc();
    n = find_ev(s, e);
    chk("turn_found", n, 1);
    chk("turn_gap", e.cyc, s + 1 + TURN_CYCLES);
    chk("turn_dir", e.rd, 1);

    // write continuation arrives 2 cycles late while reads wait
    rg = 1'b0;
    wg = 1'b1;
    push_chain(1'b0, 1);
    for (int i = 0; i < 20 && wq.size() != 0; i++) cyc();
    chk("hold_w0_taken", wq.size(), 0);
    k = cycle_n;
    push_chain(1'b1, 1);
    push_chain(1'b1, 1);
    push_chain(1'b1, 1);
    push_chain(1'b1, 1);
    rg = 1'b1;
    cyc();
    wq.push_back(mk(1'b0, 1'b1));
    repeat (25) cyc();
    n = find_ev(k, e);
    chk("hold_next_dir", e.rd, 0);
    chk("hold_next_seq", e.seq, 1);
    n = find_ev(e.cyc + 1, e2);
    chk("hold_then_read", e2.rd, 1);

    // controller stall with reads pending
    wg = 1'b0;
    push_chain(1'b1, 1);
    push_chain(1'b1, 1);
    push_chain(1'b1, 1);
    push_chain(1'b1, 1);
    push_chain(1'b1, 1);
    push_chain(1'b1, 1);
    push_chain(1'b1, 1);
    push_chain(1'b1, 1);
    for (int i = 0; i < 20 && rq.size() > 6; i++) cyc();
    k = cycle_n;
    cacc = 1'b0;
    repeat (5) cyc();
    @(negedge clock);
    chk("stall_valid", ctl_valid_o, 1);
    cacc = 1'b1;
    repeat (12) cyc();
    chk("stall_no_acc", count_ev(k + 1, k + 5), 0);
    chk("stall_resume", count_ev(k + 6, k + 8), 3);

    // both sources saturated with single-command chains
    for (int i = 0; i < 20; i++) begin
      push_chain(1'b0, 1);
      push_chain(1'b1, 1);
    end
    wg = 1'b1;
    rg = 1'b1;
    s = cycle_n + 1;
    for (int i = 0; i < 400 && (wq.size() != 0 || rq.size() != 0); i++) cyc();
    repeat (5) cyc();
    foreach (log_q[i]) if (log_q[i].cyc >= s) dirs.push_back(log_q[i].rd);
    chk("sat_total", dirs.size(), 40);
    if (dirs.size() > 0) begin
      chk("sat_first_dir", dirs[0], 0);
      runs.push_back(1);
      for (int i = 1; i < dirs.size(); i++) begin
        if (dirs[i] == dirs[i - 1]) runs[runs.size() - 1]++;
        else runs.push_back(1);
      end
      for (int i = 0; i < runs.size() - 1; i++) chk($sformatf("sat_run%0d", i), runs[i], MAX_SAME);
      chk("sat_last_run_le", (runs[runs.size() - 1] <= MAX_SAME) ? 1 : 0, 1);
    end

    // reset in the middle of a write chain
    rg = 1'b0;
    wg = 1'b1;
    push_chain(1'b0, 6);
    for (int i = 0; i < 30 && wq.size() > 3; i++) cyc();
    rst_v = 1'b1;
    cyc();
    rst_v = 1'b0;
    push_chain(1'b1, 1);
    push_chain(1'b1, 1);
    push_chain(1'b1, 1);
    rg = 1'b1;
    cyc();
    k = cycle_n;
    @(negedge clock);
    chk("prst_valid", ctl_valid_o, 0);
    chk("prst_wacc", wr_accept_o, 0);
    chk("prst_racc", rd_accept_o, 0);
    repeat (30) cyc();
    n = find_ev(k, e);
    chk("prst_found", n, 1);
    chk("prst_first_read", e.rd, 1);

    // randomized soak against the scoreboard
    rand_mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (wq.size() < 6 && $urandom_range(0, 3) == 0) push_chain(1'b0, $urandom_range(1, 4));
      if (rq.size() < 6 && $urandom_range(0, 3) == 0) push_chain(1'b1, $urandom_range(1, 4));
      cyc();
    end
    rand_mode = 1'b0;
    wg = 1'b1;
    rg = 1'b1;
    cacc = 1'b1;
    for (int i = 0; i < 500 && (wq.size() + rq.size() + sb.size()) != 0; i++) cyc();
    repeat (3) cyc();
    chk("drain_left", wq.size() + rq.size() + sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
